// File: rtl/add8u_err_profiler.sv
// add8u_err_profiler
// Exhaustive error characterisation harness for 8-bit unsigned approximate
// adders. Drives every (op_a, op_b) pair into the adder under test, compares
// the returned 9-bit sum against the exact sum and accumulates error count,
// sum of absolute errors and worst-case error (with its operands).
// Optional feature macro: PROF_MSE_EN adds sq_err_sum (sum of squared errors).
module add8u_err_profiler #(
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [7:0]       op_a,
    output logic [7:0]       op_b,
    input  logic [8:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [24:0]      abs_err_sum,
    output logic [8:0]       wce,
    output logic [7:0]       wce_a,
`ifdef PROF_MSE_EN
    output logic [7:0]       wce_b,
    output logic [33:0]      sq_err_sum
`else
    output logic [7:0]       wce_b
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(DUT_LAT);

    // Magnitude of a 10-bit two's complement difference, as 9 bits.
    function automatic logic [8:0] abs_diff(input logic [8:0] x, input logic [8:0] y);
        logic [9:0] diff;
        logic [9:0] neg;
        diff = {1'b0, x} - {1'b0, y};
        neg  = 10'd0 - diff;
        if (diff[9]) begin
            return neg[8:0];
        end else begin
            return diff[8:0];
        end
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       opcnt_q, opcnt_d;
    logic [2:0]        drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr_s;

    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [24:0]       abs_sum_q, abs_sum_d;
    logic [8:0]        wce_q, wce_d;
    logic [7:0]        wce_a_q, wce_a_d;
    logic [7:0]        wce_b_q, wce_b_d;

    // Stage-0 reference: what is being presented to the adder right now.
    logic              vld0_s;
    logic [8:0]        exact0_s;

    // Reference aligned with the adder's returned sum.
    logic              cmp_vld_s;
    logic [8:0]        cmp_exact_s;
    logic [7:0]        cmp_a_s;
    logic [7:0]        cmp_b_s;
    logic [8:0]        abs_err_s;

    assign vld0_s   = (state_q == ST_RUN);
    assign exact0_s = {1'b0, opcnt_q[7:0]} + {1'b0, opcnt_q[15:8]};

    // Sweep sequencing: operand counter, drain timer and accumulator clear.
    always_comb begin
        state_d = state_q;
        opcnt_d = opcnt_q;
        drain_d = drain_q;
        clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    opcnt_d = 16'd0;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (opcnt_q == 16'hFFFF) begin
                    state_d = ST_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    opcnt_d = opcnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // FSM and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opcnt_q <= 16'd0;
            drain_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opcnt_q <= opcnt_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cmp_vld_s   = vld0_s;
            assign cmp_exact_s = exact0_s;
            assign cmp_a_s     = opcnt_q[7:0];
            assign cmp_b_s     = opcnt_q[15:8];
        end else begin : g_pipe
            logic       vld_pipe_q   [DUT_LAT];
            logic [8:0] exact_pipe_q [DUT_LAT];
            logic [7:0] a_pipe_q     [DUT_LAT];
            logic [7:0] b_pipe_q     [DUT_LAT];

            // Delay the reference so it lines up with the adder's latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        vld_pipe_q[i]   <= 1'b0;
                        exact_pipe_q[i] <= 9'd0;
                        a_pipe_q[i]     <= 8'd0;
                        b_pipe_q[i]     <= 8'd0;
                    end
                end else begin
                    vld_pipe_q[0]   <= vld0_s;
                    exact_pipe_q[0] <= exact0_s;
                    a_pipe_q[0]     <= opcnt_q[7:0];
                    b_pipe_q[0]     <= opcnt_q[15:8];
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_pipe_q[i]   <= vld_pipe_q[i-1];
                        exact_pipe_q[i] <= exact_pipe_q[i-1];
                        a_pipe_q[i]     <= a_pipe_q[i-1];
                        b_pipe_q[i]     <= b_pipe_q[i-1];
                    end
                end
            end

            assign cmp_vld_s   = vld_pipe_q[DUT_LAT-1];
            assign cmp_exact_s = exact_pipe_q[DUT_LAT-1];
            assign cmp_a_s     = a_pipe_q[DUT_LAT-1];
            assign cmp_b_s     = b_pipe_q[DUT_LAT-1];
        end
    endgenerate

    assign abs_err_s = abs_diff(approx_sum, cmp_exact_s);

`ifdef PROF_MSE_EN
    logic [17:0] sq_err_s;
    logic [33:0] sq_sum_q, sq_sum_d;

    assign sq_err_s = {9'd0, abs_err_s} * {9'd0, abs_err_s};

    // Squared-error accumulator next state; same clear/hold rules as abs sum.
    always_comb begin
        sq_sum_d = sq_sum_q;
        if (clr_s) begin
            sq_sum_d = 34'd0;
        end else if (cmp_vld_s) begin
            sq_sum_d = sq_sum_q + {16'd0, sq_err_s};
        end else begin
            sq_sum_d = sq_sum_q;
        end
    end

    // Squared-error accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_sum_q <= 34'd0;
        end else begin
            sq_sum_q <= sq_sum_d;
        end
    end

    assign sq_err_sum = sq_sum_q;
`endif

    // Metric accumulation; strict greater-than keeps the first worst case.
    always_comb begin
        err_cnt_d = err_cnt_q;
        abs_sum_d = abs_sum_q;
        wce_d     = wce_q;
        wce_a_d   = wce_a_q;
        wce_b_d   = wce_b_q;
        if (clr_s) begin
            err_cnt_d = '0;
            abs_sum_d = 25'd0;
            wce_d     = 9'd0;
            wce_a_d   = 8'd0;
            wce_b_d   = 8'd0;
        end else if (cmp_vld_s) begin
            err_cnt_d = err_cnt_q + CNT_W'(abs_err_s != 9'd0);
            abs_sum_d = abs_sum_q + {16'd0, abs_err_s};
            if (abs_err_s > wce_q) begin
                wce_d   = abs_err_s;
                wce_a_d = cmp_a_s;
                wce_b_d = cmp_b_s;
            end else begin
                wce_d   = wce_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Metric registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            abs_sum_q <= 25'd0;
            wce_q     <= 9'd0;
            wce_a_q   <= 8'd0;
            wce_b_q   <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
            abs_sum_q <= abs_sum_d;
            wce_q     <= wce_d;
            wce_a_q   <= wce_a_d;
            wce_b_q   <= wce_b_d;
        end
    end

    assign op_a        = opcnt_q[7:0];
    assign op_b        = opcnt_q[15:8];
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cnt     = err_cnt_q;
    assign abs_err_sum = abs_sum_q;
    assign wce         = wce_q;
    assign wce_a       = wce_a_q;
    assign wce_b       = wce_b_q;

endmodule

// File: tb/tb_add8u_err_profiler.sv
// Bench for add8u_err_profiler. Four profilers sweep in parallel against
// stub adders: exact (latency 0), LSB-OR (latency 0), constant zero
// (latency 2) and LSB-OR (latency 1, reset mid-sweep then restarted).
// Expected metrics come from a behavioural loop over all operand pairs.
module tb_add8u_err_profiler;

    typedef struct {
        int          inst;
        logic [16:0] err;
        logic [24:0] abs_sum;
        logic [8:0]  wce;
        logic [7:0]  wa;
        logic [7:0]  wb;
        logic [33:0] sq;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n_main;
    logic        rst_n_3;
    logic [3:0]  start_w;
    logic [7:0]  op_a_w [4];
    logic [7:0]  op_b_w [4];
    logic [8:0]  sum_w  [4];
    logic [3:0]  busy_w;
    logic [3:0]  done_w;
    logic [16:0] err_w  [4];
    logic [24:0] abs_w  [4];
    logic [8:0]  wce_w  [4];
    logic [7:0]  wa_w   [4];
    logic [7:0]  wb_w   [4];
    logic [33:0] sq_w   [4];
    logic [8:0]  dly2a_q = 9'd0;
    logic [8:0]  dly2b_q = 9'd0;
    logic [8:0]  dly3_q  = 9'd0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt [4];
    exp_t        sb_q [$];
    exp_t        last_exp [4];

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] stub_f(input int mode, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (mode)
            0: return s;
            1: begin
                s[0] = a[0] | b[0];
                return s;
            end
            default: return 9'd0;
        endcase
    endfunction

    // Stub adders: combinational for instances 0/1, delayed for 2/3.
    always_comb begin
        sum_w[0] = stub_f(0, op_a_w[0], op_b_w[0]);
        sum_w[1] = stub_f(1, op_a_w[1], op_b_w[1]);
        sum_w[2] = dly2b_q;
        sum_w[3] = dly3_q;
    end

    // Latency registers of the delayed stubs.
    always @(posedge clk) begin
        dly2a_q <= stub_f(2, op_a_w[2], op_b_w[2]);
        dly2b_q <= dly2a_q;
        dly3_q  <= stub_f(1, op_a_w[3], op_b_w[3]);
    end

`ifdef PROF_MSE_EN
    `define SQ_PORT(i) , .sq_err_sum(sq_w[i])
`else
    `define SQ_PORT(i)
    initial for (int i = 0; i < 4; i++) sq_w[i] = 34'd0;
`endif

    add8u_err_profiler #(.DUT_LAT(0), .CNT_W(17)) u_exact (
        .clk(clk), .rst_n(rst_n_main), .start(start_w[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]),
        .approx_sum(sum_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err_cnt(err_w[0]),
        .abs_err_sum(abs_w[0]), .wce(wce_w[0]), .wce_a(wa_w[0]), .wce_b(wb_w[0]) `SQ_PORT(0));
    add8u_err_profiler #(.DUT_LAT(0), .CNT_W(17)) u_orlsb (
        .clk(clk), .rst_n(rst_n_main), .start(start_w[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]),
        .approx_sum(sum_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err_cnt(err_w[1]),
        .abs_err_sum(abs_w[1]), .wce(wce_w[1]), .wce_a(wa_w[1]), .wce_b(wb_w[1]) `SQ_PORT(1));
    add8u_err_profiler #(.DUT_LAT(2), .CNT_W(17)) u_zero (
        .clk(clk), .rst_n(rst_n_main), .start(start_w[2]), .op_a(op_a_w[2]), .op_b(op_b_w[2]),
        .approx_sum(sum_w[2]), .busy(busy_w[2]), .done(done_w[2]), .err_cnt(err_w[2]),
        .abs_err_sum(abs_w[2]), .wce(wce_w[2]), .wce_a(wa_w[2]), .wce_b(wb_w[2]) `SQ_PORT(2));
    add8u_err_profiler #(.DUT_LAT(1), .CNT_W(17)) u_rst (
        .clk(clk), .rst_n(rst_n_3), .start(start_w[3]), .op_a(op_a_w[3]), .op_b(op_b_w[3]),
        .approx_sum(sum_w[3]), .busy(busy_w[3]), .done(done_w[3]), .err_cnt(err_w[3]),
        .abs_err_sum(abs_w[3]), .wce(wce_w[3]), .wce_a(wa_w[3]), .wce_b(wb_w[3]) `SQ_PORT(3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference metrics over a full sweep, operand order {b,a} ascending.
    function automatic exp_t build_exp(input int inst, input int mode, input int start_cyc, input int lat);
        exp_t    e;
        longint  err_n, abs_n, sq_n;
        int      worst, d, ae;
        err_n = 0; abs_n = 0; sq_n = 0; worst = 0;
        e.inst = inst; e.wa = 8'd0; e.wb = 8'd0;
        for (int b = 0; b < 256; b++) begin
            for (int a = 0; a < 256; a++) begin
                d  = int'(stub_f(mode, 8'(a), 8'(b))) - (a + b);
                ae = (d < 0) ? -d : d;
                if (ae != 0) err_n++;
                abs_n += ae;
                sq_n  += longint'(ae) * longint'(ae);
                if (ae > worst) begin
                    worst = ae;
                    e.wa  = 8'(a);
                    e.wb  = 8'(b);
                end
            end
        end
        e.err      = 17'(err_n);
        e.abs_sum  = 25'(abs_n);
        e.wce      = 9'(worst);
        e.sq       = 34'(sq_n);
        e.done_cyc = start_cyc + 65538 + lat;
        return e;
    endfunction

    task automatic check_zero(input int i, input string tag);
        check({tag, "_busy"}, 64'(busy_w[i]), 64'd0);
        check({tag, "_done"}, 64'(done_w[i]), 64'd0);
        check({tag, "_ops"}, {48'd0, op_b_w[i], op_a_w[i]}, 64'd0);
        check({tag, "_err"}, 64'(err_w[i]), 64'd0);
        check({tag, "_abs"}, 64'(abs_w[i]), 64'd0);
        check({tag, "_wce"}, {39'd0, wce_w[i], wa_w[i], wb_w[i]}, 64'd0);
    endtask

    task automatic check_result(input int i, input exp_t e, input string tag);
        check({tag, "_err_cnt"}, 64'(err_w[i]), 64'(e.err));
        check({tag, "_abs_sum"}, 64'(abs_w[i]), 64'(e.abs_sum));
        check({tag, "_wce"}, 64'(wce_w[i]), 64'(e.wce));
        check({tag, "_wce_a"}, 64'(wa_w[i]), 64'(e.wa));
        check({tag, "_wce_b"}, 64'(wb_w[i]), 64'(e.wb));
`ifdef PROF_MSE_EN
        check({tag, "_sq_sum"}, 64'(sq_w[i]), 64'(e.sq));
`endif
    endtask

    initial begin
        int   s0, idx;
        bit   or_chk, started3, found, finished;
        exp_t e;
        string names [4];
        names[0] = "exact"; names[1] = "orlsb"; names[2] = "zero"; names[3] = "rst";
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        or_chk = 1'b0; started3 = 1'b0; finished = 1'b0;
        rst_n_main = 1'b0;
        rst_n_3    = 1'b0;
        start_w    = 4'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check_zero(i, {"reset_", names[i]});
        rst_n_main = 1'b1;
        rst_n_3    = 1'b1;
        repeat (2) @(negedge clk);

        // Launch all four sweeps together.
        s0 = cyc;
        start_w = 4'b1111;
        sb_q.push_back(build_exp(0, 0, s0, 0));
        sb_q.push_back(build_exp(1, 1, s0, 0));
        sb_q.push_back(build_exp(2, 2, s0, 2));
        @(negedge clk);
        start_w = 4'd0;
        check("busy_after_start", 64'(busy_w), 64'hF);

        for (int c = 0; c < 80000 && !finished; c++) begin
            idx = cyc - s0 - 1;
            if (idx == 0 || idx == 255 || idx == 256 || idx == 65535 || idx == 65537)
                check($sformatf("op_seq_%0d", idx), {48'd0, op_b_w[0], op_a_w[0]},
                      64'((idx > 65535) ? 65535 : idx));
            if (idx == 999) start_w[0] = 1'b1;
            else start_w[0] = 1'b0;
            if (idx == 2999) begin
                rst_n_3 = 1'b0;
                #1;
                check_zero(3, "midsweep_reset");
            end
            if (idx == 3002) rst_n_3 = 1'b1;
            if (idx == 3004) begin
                start_w[3] = 1'b1;
                started3 = 1'b1;
                sb_q.push_back(build_exp(3, 1, cyc, 1));
            end else begin
                start_w[3] = 1'b0;
            end
            if (or_chk) begin
                start_w[1] = 1'b0;
                or_chk = 1'b0;
                check("start_on_done_ignored", 64'(busy_w[1]), 64'd0);
            end
            for (int i = 0; i < 4; i++) begin
                if (done_w[i]) begin
                    done_cnt[i]++;
                    found = 1'b0;
                    for (int k = 0; k < sb_q.size(); k++) begin
                        if (!found && sb_q[k].inst == i) begin
                            e = sb_q[k];
                            sb_q.delete(k);
                            found = 1'b1;
                        end
                    end
                    check({"done_expected_", names[i]}, 64'(found), 64'd1);
                    if (found) begin
                        last_exp[i] = e;
                        check({"done_cycle_", names[i]}, 64'(cyc), 64'(e.done_cyc));
                        check({"busy_at_done_", names[i]}, 64'(busy_w[i]), 64'd1);
                        check_result(i, e, names[i]);
                    end
                    if (i == 1) begin
                        start_w[1] = 1'b1;
                        or_chk = 1'b1;
                    end
                end
            end
            finished = started3 && (sb_q.size() == 0) && !or_chk;
            @(negedge clk);
        end
        check("all_sweeps_finished", 64'(sb_q.size()), 64'd0);

        // Results must hold after done and no stray done pulses may appear.
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_w[i]) done_cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            check({"done_pulses_", names[i]}, 64'(done_cnt[i]), 64'd1);
            check({"idle_", names[i]}, 64'(busy_w[i]), 64'd0);
        end
        check_result(2, last_exp[2], "hold_zero");
        check_result(0, last_exp[0], "hold_exact");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
